// File: rtl/com_bus_arbiter.sv
// Two-channel coherence bus arbiter (proc: 8 cores, snoop: 4 snoopers + memory).
// Define ARB_ROUND_ROBIN_EN for rotating-pointer arbitration; fixed priority otherwise.
module com_bus_arbiter_ch #(
  parameter int W        = 8,
  parameter int IDLE_GAP = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t       state, state_nx;
  logic [W-1:0] gnt_nx;
  logic [W-1:0] win;
  logic [2:0]   start;

  // First requester found walking the ring from start, wrapping at W.
  function automatic logic [W-1:0] pick(input logic [W-1:0] r, input logic [2:0] s);
    logic [W-1:0] g;
    int           i;
    g = '0;
    for (int k = 0; k < W; k++) begin
      i = int'(s) + k;
      if (i >= W) i = i - W;
      if (g == '0 && r[i]) g[i] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [2:0] after(input logic [W-1:0] g);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 0; i < W; i++)
      if (g[i]) p = (i == W - 1) ? 3'd0 : 3'(i + 1);
    return p;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  logic [2:0] ptr;
  logic       issue;

  // A fresh grant is any nonzero next vector that differs from the current owner.
  assign issue = (gnt_nx != '0) && (gnt_nx != gnt);
  assign start = ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ptr <= 3'd0;
    else if (issue) ptr <= after(gnt_nx);
  end
`else
  assign start = 3'd0;
`endif

  assign win = pick(req, start);

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    case (state)
      IDLE, GAP: begin
        gnt_nx   = win;
        state_nx = (win != '0) ? GRANT : IDLE;
      end
      GRANT: begin
        if ((gnt & req) == '0) begin
          if (IDLE_GAP == 1) begin
            gnt_nx   = '0;
            state_nx = GAP;
          end else begin
            gnt_nx   = win;
            state_nx = (win != '0) ? GRANT : IDLE;
          end
        end
      end
      default: begin
        gnt_nx   = '0;
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
    end
  end
endmodule

module com_bus_arbiter #(
  parameter int IDLE_GAP = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic Com_Bus_Req_proc_0,
  input  logic Com_Bus_Req_proc_1,
  input  logic Com_Bus_Req_proc_2,
  input  logic Com_Bus_Req_proc_3,
  input  logic Com_Bus_Req_proc_4,
  input  logic Com_Bus_Req_proc_5,
  input  logic Com_Bus_Req_proc_6,
  input  logic Com_Bus_Req_proc_7,
  input  logic Com_Bus_Req_snoop_0,
  input  logic Com_Bus_Req_snoop_1,
  input  logic Com_Bus_Req_snoop_2,
  input  logic Com_Bus_Req_snoop_3,
  input  logic Mem_snoop_req,
  output logic Com_Bus_Gnt_proc_0,
  output logic Com_Bus_Gnt_proc_1,
  output logic Com_Bus_Gnt_proc_2,
  output logic Com_Bus_Gnt_proc_3,
  output logic Com_Bus_Gnt_proc_4,
  output logic Com_Bus_Gnt_proc_5,
  output logic Com_Bus_Gnt_proc_6,
  output logic Com_Bus_Gnt_proc_7,
  output logic Com_Bus_Gnt_snoop_0,
  output logic Com_Bus_Gnt_snoop_1,
  output logic Com_Bus_Gnt_snoop_2,
  output logic Com_Bus_Gnt_snoop_3,
  output logic Mem_snoop_gnt
);
  logic [7:0] proc_req, proc_gnt;
  logic [4:0] snoop_req, snoop_gnt;

  assign proc_req = {Com_Bus_Req_proc_7, Com_Bus_Req_proc_6, Com_Bus_Req_proc_5,
                     Com_Bus_Req_proc_4, Com_Bus_Req_proc_3, Com_Bus_Req_proc_2,
                     Com_Bus_Req_proc_1, Com_Bus_Req_proc_0};
  // Memory occupies the last ring slot after the four snoopers.
  assign snoop_req = {Mem_snoop_req, Com_Bus_Req_snoop_3, Com_Bus_Req_snoop_2,
                      Com_Bus_Req_snoop_1, Com_Bus_Req_snoop_0};

  com_bus_arbiter_ch #(.W(8), .IDLE_GAP(IDLE_GAP)) u_proc (
    .clk(clk), .rst_n(rst_n), .req(proc_req), .gnt(proc_gnt)
  );

  com_bus_arbiter_ch #(.W(5), .IDLE_GAP(IDLE_GAP)) u_snoop (
    .clk(clk), .rst_n(rst_n), .req(snoop_req), .gnt(snoop_gnt)
  );

  assign {Com_Bus_Gnt_proc_7, Com_Bus_Gnt_proc_6, Com_Bus_Gnt_proc_5, Com_Bus_Gnt_proc_4,
          Com_Bus_Gnt_proc_3, Com_Bus_Gnt_proc_2, Com_Bus_Gnt_proc_1, Com_Bus_Gnt_proc_0} = proc_gnt;
  assign {Mem_snoop_gnt, Com_Bus_Gnt_snoop_3, Com_Bus_Gnt_snoop_2,
          Com_Bus_Gnt_snoop_1, Com_Bus_Gnt_snoop_0} = snoop_gnt;
endmodule

// File: tb/tb_com_bus_arbiter.sv
// Bench for com_bus_arbiter: directed scenarios plus random requests, two instances (IDLE_GAP 0 and 1)
// compared every cycle against an owner/ring-position reference model.
module tb_com_bus_arbiter;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rp = '0;
  logic [3:0] rs = '0;
  logic       rm = 1'b0;
  logic [7:0] gp0, gp1;
  logic [3:0] gs0, gs1;
  logic       gm0, gm1;

  int n_tests = 0;
  int n_fail  = 0;

  int own_p[2], own_s[2], st_p[2], st_s[2];
  bit gap_p[2], gap_s[2];

  always #5 clk = ~clk;

  com_bus_arbiter #(.IDLE_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc_0(rp[0]), .Com_Bus_Req_proc_1(rp[1]), .Com_Bus_Req_proc_2(rp[2]),
    .Com_Bus_Req_proc_3(rp[3]), .Com_Bus_Req_proc_4(rp[4]), .Com_Bus_Req_proc_5(rp[5]),
    .Com_Bus_Req_proc_6(rp[6]), .Com_Bus_Req_proc_7(rp[7]),
    .Com_Bus_Req_snoop_0(rs[0]), .Com_Bus_Req_snoop_1(rs[1]),
    .Com_Bus_Req_snoop_2(rs[2]), .Com_Bus_Req_snoop_3(rs[3]), .Mem_snoop_req(rm),
    .Com_Bus_Gnt_proc_0(gp0[0]), .Com_Bus_Gnt_proc_1(gp0[1]), .Com_Bus_Gnt_proc_2(gp0[2]),
    .Com_Bus_Gnt_proc_3(gp0[3]), .Com_Bus_Gnt_proc_4(gp0[4]), .Com_Bus_Gnt_proc_5(gp0[5]),
    .Com_Bus_Gnt_proc_6(gp0[6]), .Com_Bus_Gnt_proc_7(gp0[7]),
    .Com_Bus_Gnt_snoop_0(gs0[0]), .Com_Bus_Gnt_snoop_1(gs0[1]),
    .Com_Bus_Gnt_snoop_2(gs0[2]), .Com_Bus_Gnt_snoop_3(gs0[3]), .Mem_snoop_gnt(gm0)
  );

  com_bus_arbiter #(.IDLE_GAP(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .Com_Bus_Req_proc_0(rp[0]), .Com_Bus_Req_proc_1(rp[1]), .Com_Bus_Req_proc_2(rp[2]),
    .Com_Bus_Req_proc_3(rp[3]), .Com_Bus_Req_proc_4(rp[4]), .Com_Bus_Req_proc_5(rp[5]),
    .Com_Bus_Req_proc_6(rp[6]), .Com_Bus_Req_proc_7(rp[7]),
    .Com_Bus_Req_snoop_0(rs[0]), .Com_Bus_Req_snoop_1(rs[1]),
    .Com_Bus_Req_snoop_2(rs[2]), .Com_Bus_Req_snoop_3(rs[3]), .Mem_snoop_req(rm),
    .Com_Bus_Gnt_proc_0(gp1[0]), .Com_Bus_Gnt_proc_1(gp1[1]), .Com_Bus_Gnt_proc_2(gp1[2]),
    .Com_Bus_Gnt_proc_3(gp1[3]), .Com_Bus_Gnt_proc_4(gp1[4]), .Com_Bus_Gnt_proc_5(gp1[5]),
    .Com_Bus_Gnt_proc_6(gp1[6]), .Com_Bus_Gnt_proc_7(gp1[7]),
    .Com_Bus_Gnt_snoop_0(gs1[0]), .Com_Bus_Gnt_snoop_1(gs1[1]),
    .Com_Bus_Gnt_snoop_2(gs1[2]), .Com_Bus_Gnt_snoop_3(gs1[3]), .Mem_snoop_gnt(gm1)
  );

  task automatic chk(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  function automatic int pick_m(input logic [7:0] r, input int start, input int n);
    for (int k = 0; k < n; k++)
      if (r[(start + k) % n]) return (start + k) % n;
    return -1;
  endfunction

  // One clock edge of one channel: hold, release (optionally into a dead cycle), or arbitrate.
  task automatic step(input logic [7:0] r, input int n, input int gapcfg,
                      inout int own, inout bit gap, inout int start);
    int w;
    if (own >= 0 && r[own]) return;
    if (own >= 0) begin
      own = -1;
      if (gapcfg != 0) begin
        gap = 1'b1;
        return;
      end
    end
    gap = 1'b0;
    w = pick_m(r, RR ? start : 0, n);
    if (w >= 0) begin
      own   = w;
      start = (w + 1) % n;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      own_p[d] = -1; own_s[d] = -1; st_p[d] = 0; st_s[d] = 0;
      gap_p[d] = 1'b0; gap_s[d] = 1'b0;
    end
  endtask

  function automatic logic [12:0] exp_vec(input int d);
    logic [12:0] v;
    v = '0;
    if (own_p[d] >= 0) v[own_p[d]] = 1'b1;
    if (own_s[d] >= 0) v[8 + own_s[d]] = 1'b1;
    return v;
  endfunction

  function automatic logic [12:0] got_vec(input int d);
    return (d == 0) ? {gm0, gs0, gp0} : {gm1, gs1, gp1};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      for (int d = 0; d < 2; d++) begin
        step(rp, 8, d, own_p[d], gap_p[d], st_p[d]);
        step({3'b000, rm, rs}, 5, d, own_s[d], gap_s[d], st_s[d]);
      end
    end
    #1;
    chk("gnt_gap0", got_vec(0), exp_vec(0));
    chk("gnt_gap1", got_vec(1), exp_vec(1));
  endtask

  task automatic async_reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_gap0", got_vec(0), 13'h0);
    chk("async_rst_gap1", got_vec(1), 13'h0);
  endtask

  initial begin
    model_reset();
    rp = 8'hFF; rs = 4'hF; rm = 1'b1;
    tick();
    tick();
    chk("rst_zero", got_vec(0), 13'h0);
    rst_n = 1'b1;
    tick();
    chk("first_gnt", got_vec(0), {1'b0, 4'b0001, 8'h01});

    rp = '0; rs = '0; rm = 1'b0;
    repeat (3) tick();
    rp = 8'h08;
    tick();
    chk("single_p3", {5'b0, gp0}, {5'b0, 8'h08});
    repeat (3) tick();
    rp = 8'h00;
    tick();
    chk("drop_p3", {5'b0, gp0}, 13'h0);
    tick();

    rp = 8'h01; tick(); tick();
    rp = 8'h45; tick(); tick();
    chk("hold_p0", {5'b0, gp0}, {5'b0, 8'h01});
    rp = 8'h44; tick();
    chk("next_p2", {5'b0, gp0}, {5'b0, 8'h04});
    tick();
    rp = 8'h40; tick();
    chk("next_p6", {5'b0, gp0}, {5'b0, 8'h40});
    rp = 8'h41; tick(); tick();
    rp = 8'h01; tick();
    chk("wrap_p0", {5'b0, gp0}, {5'b0, 8'h01});
    tick();

    rp = 8'h02; rs = 4'b0100; rm = 1'b1;
    tick();
    chk("conc_s2", {gm0, gs0, gp0}, {1'b0, 4'b0100, 8'h02});
    tick(); tick();
    rs = 4'b0000;
    tick();
    chk("conc_mem", {gm0, gs0, gp0}, {1'b1, 4'b0000, 8'h02});
    tick(); tick();

    rm = 1'b0; rs = 4'b0010;
    tick(); tick();
    chk("pre_rst_s1", {gm0, gs0}, 5'b00010);
    async_reset_pulse();
    rs = 4'b1111; rm = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("restart_s0", {gm0, gs0}, 5'b00001);

    for (int c = 0; c < 800; c++) begin
      rst_n = 1'b1;
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 3) == 0) rp[b] = ~rp[b];
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) rs[b] = ~rs[b];
      if ($urandom_range(0, 4) == 0) rm = ~rm;
      tick();
      if ($urandom_range(0, 149) == 0) async_reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
